// File: rtl/branch_resolve_pkg.sv
// rtl/branch_resolve_pkg.sv - shared funct3 codes and FSM state type for branch resolution
package riscv_br_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_RSV2 = 3'b010;
  localparam logic [2:0] F3_RSV3 = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    FLUSH = 2'd2
  } br_state_t;

  function automatic logic word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - execute-side branch, comparator, redirect and status bundle
interface branch_resolve_if #(
  parameter int CNT_W = 32
);
  logic             br_valid;
  logic             br_ready;
  logic             br_is_jump;
  logic [2:0]       br_funct3;
  logic [31:0]      br_pc;
  logic [31:0]      br_imm;
  logic             c_s_un;
  logic             eq_flag;
  logic             lt_flag;
  logic             redirect_valid;
  logic             redirect_ready;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic             misalign;
  logic             illegal;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  // master is the resolve unit; slave is the surrounding pipeline/fetch/comparator
  modport master (
    input  br_valid, br_is_jump, br_funct3, br_pc, br_imm, eq_flag, lt_flag, redirect_ready,
    output br_ready, c_s_un, redirect_valid, redirect_pc, flush, misalign, illegal,
           br_count, taken_count
  );

  modport slave (
    output br_valid, br_is_jump, br_funct3, br_pc, br_imm, eq_flag, lt_flag, redirect_ready,
    input  br_ready, c_s_un, redirect_valid, redirect_pc, flush, misalign, illegal,
           br_count, taken_count
  );
endinterface

// File: rtl/branch_resolve_cond.sv
// rtl/branch_resolve_cond.sv - maps condition code and comparator flags to taken/illegal
import riscv_br_pkg::*;

module branch_cond (
  input  logic [2:0] i_funct3,
  input  logic       i_is_jump,
  input  logic       i_eq,
  input  logic       i_lt,
  output logic       o_taken,
  output logic       o_illegal
);

  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    if (i_is_jump) begin
      o_taken = 1'b1;
    end else begin
      case (i_funct3)
        F3_BEQ:           o_taken = i_eq;
        F3_BNE:           o_taken = ~i_eq;
        F3_BLT, F3_BLTU:  o_taken = i_lt;
        F3_BGE, F3_BGEU:  o_taken = ~i_lt;
        default:          o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - branch resolution FSM, target adder, flush counter and perf counters
import riscv_br_pkg::*;

module branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic            clk,
  input  logic            rst,
  branch_resolve_if.master bus
);

  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  br_state_t        r_state;
  logic             r_br_ready;
  logic             r_redirect_valid;
  logic             r_flush;
  logic             r_misalign;
  logic             r_illegal;
  logic [31:0]      r_redirect_pc;
  logic [FC_W-1:0]  r_flush_cnt;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_taken_count;

  logic             w_taken;
  logic             w_illegal;
  logic             w_accept;
  logic             w_handshake;
  logic             w_aligned;
  logic [31:0]      w_target;

  branch_cond u_cond (
    .i_funct3  (bus.br_funct3),
    .i_is_jump (bus.br_is_jump),
    .i_eq      (bus.eq_flag),
    .i_lt      (bus.lt_flag),
    .o_taken   (w_taken),
    .o_illegal (w_illegal)
  );

  // Comparator mode must follow funct3 in the same cycle, so this stays combinational
  assign bus.c_s_un = bus.br_funct3[1];

  assign w_target    = bus.br_pc + bus.br_imm;
  assign w_aligned   = word_aligned(w_target);
  assign w_accept    = bus.br_valid & r_br_ready;
  assign w_handshake = r_redirect_valid & bus.redirect_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_br_ready       <= 1'b1;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush          <= 1'b0;
      r_flush_cnt      <= '0;
      r_misalign       <= 1'b0;
      r_illegal        <= 1'b0;
    end else begin
      r_misalign <= w_accept & w_taken & ~w_aligned;
      r_illegal  <= w_accept & w_illegal;
      case (r_state)
        IDLE: begin
          if (w_accept && w_taken && w_aligned) begin
            r_state          <= REDIR;
            r_redirect_pc    <= w_target;
            r_redirect_valid <= 1'b1;
            r_br_ready       <= 1'b0;
          end
        end
        REDIR: begin
          if (bus.redirect_ready) begin
            r_redirect_valid <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              r_state    <= IDLE;
              r_br_ready <= 1'b1;
            end else begin
              r_state     <= FLUSH;
              r_flush     <= 1'b1;
              r_flush_cnt <= FC_W'(FLUSH_CYCLES);
            end
          end
        end
        FLUSH: begin
          if (r_flush_cnt == FC_W'(1)) begin
            r_state    <= IDLE;
            r_flush    <= 1'b0;
            r_br_ready <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        default: begin
          r_state          <= IDLE;
          r_br_ready       <= 1'b1;
          r_redirect_valid <= 1'b0;
          r_flush          <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else begin
      if (w_accept) begin
        r_br_count <= r_br_count + 1'b1;
      end
      if (w_handshake) begin
        r_taken_count <= r_taken_count + 1'b1;
      end
    end
  end

  assign bus.br_ready       = r_br_ready;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.flush          = r_flush;
  assign bus.misalign       = r_misalign;
  assign bus.illegal        = r_illegal;
  assign bus.br_count       = r_br_count;
  assign bus.taken_count    = r_taken_count;

endmodule
